// File: rtl/vertex_transform.sv
// rtl/vertex_transform.sv - affine 8.8 vertex transform with one time-shared multiplier
// Optional clamp on overflow: VERTEX_TRANSFORM_SAT_EN.
module vertex_transform (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0][15:0] model_matrix,
    input  logic [15:0]       vx,
    input  logic [15:0]       vy,
    input  logic [15:0]       vz,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       ox,
    output logic [15:0]       oy,
    output logic [15:0]       oz,
    output logic              overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t             state_q;
    logic [1:0]         r_q, c_q;
    logic [15:0]        m_q [12];
    logic [15:0]        v_q [3];
    logic signed [33:0] acc_q;
    logic [15:0]        ox_q, oy_q, oz_q;
    logic               ovf_q, in_ready_q, out_valid_q;

    logic signed [15:0] m_sel, v_sel, m_off;
    logic signed [31:0] prod;
    logic signed [33:0] acc_d, rnd;
    logic               row_ovf;
    logic [15:0]        row_res;
    logic               unused_row3;

    // Row 3 of the matrix is implied (0,0,0,1) and never read.
    assign unused_row3 = ^model_matrix[15:12];

    always_comb begin
        m_sel   = m_q[{r_q, c_q}];
        m_off   = m_q[{r_q, 2'b11}];
        v_sel   = v_q[c_q];
        prod    = m_sel * v_sel;
        acc_d   = ((c_q == 2'd0) ? {{10{m_off[15]}}, m_off, 8'h00} : acc_q)
                  + {{2{prod[31]}}, prod};
        rnd     = acc_d + 34'sd128;
        // Rounded value fits 8.8 only if bits [33:23] are a pure sign extension.
        row_ovf = !((&rnd[33:23]) || !(|rnd[33:23]));
        row_res = rnd[23:8];
`ifdef VERTEX_TRANSFORM_SAT_EN
        if (row_ovf) begin
            row_res = rnd[33] ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            acc_q       <= '0;
            ox_q        <= 16'h0000;
            oy_q        <= 16'h0000;
            oz_q        <= 16'h0000;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 12; k++) begin
                            m_q[k] <= model_matrix[k];
                        end
                        v_q[0]     <= vx;
                        v_q[1]     <= vy;
                        v_q[2]     <= vz;
                        r_q        <= 2'd0;
                        c_q        <= 2'd0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (c_q == 2'd2) begin
                        case (r_q)
                            2'd0:    ox_q <= row_res;
                            2'd1:    oy_q <= row_res;
                            default: oz_q <= row_res;
                        endcase
                        ovf_q <= ovf_q | row_ovf;
                        c_q   <= 2'd0;
                        if (r_q == 2'd2) begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            r_q <= r_q + 2'd1;
                        end
                    end else begin
                        c_q <= c_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ox        = ox_q;
    assign oy        = oy_q;
    assign oz        = oz_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_vertex_transform.sv
// tb/tb_vertex_transform.sv - scoreboard bench for vertex_transform
module tb_vertex_transform;

    typedef logic [15:0][15:0] mat_t;

    logic        Clk = 1'b0;
    logic        Reset;
    mat_t        model_matrix;
    logic [15:0] vx, vy, vz;
    logic        in_valid, in_ready;
    logic [15:0] ox, oy, oz;
    logic        overflow, out_valid, out_ready;

    int n_checks = 0;
    int n_pass   = 0;
    logic [48:0] exp_q [$];

    always #5 Clk = ~Clk;

    vertex_transform dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .model_matrix (model_matrix),
        .vx           (vx),
        .vy           (vy),
        .vz           (vz),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ox           (ox),
        .oy           (oy),
        .oz           (oz),
        .overflow     (overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    function automatic mat_t identity();
        mat_t m;
        m = '0;
        m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
        return m;
    endfunction

    // Reference: 8.8 affine row dot-product, round half-up, range check.
    function automatic logic [48:0] model(input mat_t m, input logic [15:0] x, y, z);
        logic [15:0] v [3];
        logic [15:0] res [3];
        longint s, q;
        logic ovf;
        v[0] = x; v[1] = y; v[2] = z;
        ovf = 1'b0;
        for (int r = 0; r < 3; r++) begin
            s = longint'($signed(m[4*r+3])) * 256;
            for (int c = 0; c < 3; c++) begin
                s = s + longint'($signed(m[4*r+c])) * longint'($signed(v[c]));
            end
            s = s + 128;
            q = s >>> 8;
            res[r] = s[23:8];
            if (q > 32767 || q < -32768) begin
                ovf = 1'b1;
`ifdef VERTEX_TRANSFORM_SAT_EN
                res[r] = (q > 0) ? 16'h7FFF : 16'h8000;
`endif
            end
        end
        return {ovf, res[2], res[1], res[0]};
    endfunction

    task automatic send(input mat_t m, input logic [15:0] x, y, z,
                        input bit push, input logic [48:0] exp_val);
        int waited;
        waited = 0;
        while (!in_ready && waited < 30) begin
            @(negedge Clk);
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL send_wait: in_ready=%b required 1", in_ready);
        else n_pass++;
        model_matrix = m; vx = x; vy = y; vz = z;
        in_valid = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        model_matrix = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        vx = 16'($urandom); vy = 16'($urandom); vz = 16'($urandom);
        if (push) exp_q.push_back(exp_val);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL accept_in_ready: in_ready=%b required 0", in_ready);
        else n_pass++;
    endtask

    task automatic receive(input int hold);
        int cyc;
        logic [48:0] snap, e;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 9) $display("FAIL latency: cycles=%0d required 9", cyc);
        else n_pass++;
        snap = {overflow, oz, oy, ox};
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(negedge Clk);
            n_checks++;
            if ({out_valid, in_ready, overflow, oz, oy, ox} !== {1'b1, 1'b0, snap})
                $display("FAIL hold_%0d: ov/ir/res=%b/%b/%h required 1/0/%h",
                         h, out_valid, in_ready, {overflow, oz, oy, ox}, snap);
            else n_pass++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: result %h with no expectation", {overflow, oz, oy, ox});
        end else begin
            e = exp_q.pop_front();
            if ({overflow, oz, oy, ox} !== e)
                $display("FAIL result: ovf/oz/oy/ox=%b/%h/%h/%h required %b/%h/%h/%h",
                         overflow, oz, oy, ox, e[48], e[47:32], e[31:16], e[15:0]);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL handoff: out_valid/in_ready=%b/%b required 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({in_ready, out_valid, overflow, ox, oy, oz} !== {1'b1, 1'b0, 1'b0, 48'h0})
            $display("FAIL reset_state: ir/ov/ovf=%b/%b/%b ox/oy/oz=%h/%h/%h required 1/0/0 0000/0000/0000",
                     in_ready, out_valid, overflow, ox, oy, oz);
        else n_pass++;
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_identity();
        send(identity(), 16'h0180, 16'hFF00, 16'h0040, 1'b1, {1'b0, 16'h0040, 16'hFF00, 16'h0180});
        receive(0);
    endtask

    task automatic test_overflow();
        mat_t m;
        m = '0;
        m[0] = 16'h7F00;
`ifdef VERTEX_TRANSFORM_SAT_EN
        send(m, 16'h0400, 16'h0, 16'h0, 1'b1, {1'b1, 16'h0000, 16'h0000, 16'h7FFF});
`else
        send(m, 16'h0400, 16'h0, 16'h0, 1'b1, {1'b1, 16'h0000, 16'h0000, 16'hFC00});
`endif
        receive(0);
    endtask

    task automatic test_translate();
        mat_t m;
        m = identity();
        m[3] = 16'h0200; m[11] = 16'hFE00;
        send(m, 16'h0100, 16'h0100, 16'h0100, 1'b1, {1'b0, 16'hFF00, 16'h0100, 16'h0300});
        receive(0);
    endtask

    task automatic test_rotate();
        mat_t m;
        m = '0;
        m[2] = 16'h0200; m[5] = 16'h0200; m[8] = 16'hFE00; m[15] = 16'h0100;
        send(m, 16'h0100, 16'h0, 16'h0, 1'b1, {1'b0, 16'hFE00, 16'h0000, 16'h0000});
        receive(0);
    endtask

    task automatic test_rounding();
        mat_t m;
        m = '0;
        m[0] = 16'h0080;
        send(m, 16'h0001, 16'h0, 16'h0, 1'b1, {1'b0, 16'h0000, 16'h0000, 16'h0001});
        receive(0);
    endtask

    task automatic test_backpressure();
        send(identity(), 16'h1234, 16'hEDCC, 16'h0007, 1'b1, {1'b0, 16'h0007, 16'hEDCC, 16'h1234});
        receive(5);
    endtask

    task automatic test_reset_mid_mac();
        int seen;
        send(identity(), 16'h0180, 16'h0200, 16'h0300, 1'b0, '0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, overflow, ox, oy, oz} !== {1'b1, 1'b0, 1'b0, 48'h0})
            $display("FAIL reset_mid_mac: ir/ov/ovf=%b/%b/%b ox/oy/oz=%h/%h/%h required 1/0/0 0000/0000/0000",
                     in_ready, out_valid, overflow, ox, oy, oz);
        else n_pass++;
        seen = 0;
        repeat (15) begin
            @(negedge Clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL reset_discard: out_valid cycles=%0d required 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        mat_t m;
        logic [15:0] x, y, z;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 16; k++) begin
                m[k] = (t < 3) ? 16'($signed(10'($urandom))) : 16'($urandom);
            end
            x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
            send(m, x, y, z, 1'b1, model(m, x, y, z));
            receive(t % 2);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        model_matrix = '0; vx = '0; vy = '0; vz = '0;
        test_reset();
        test_identity();
        test_overflow();
        test_translate();
        test_rotate();
        test_rounding();
        test_backpressure();
        test_reset_mid_mac();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
